issue_queue_mp: RTL and testbench

- Parametrised multi-port in-order issue queue; successor to the fixed 16-entry, 4-in/2-out queue between rename/dispatch and issue select.
- Generalises depth, data width and enqueue/dequeue lane counts.
- Adds what the fixed queue lacks: all-or-nothing enqueue backpressure, dequeue clamping, per-lane output valids, pipeline flush and defined reset.

---
 rtl/issue_queue_mp.sv | 112 +++++++++++
 tb/tb_issue_queue_mp.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/issue_queue_mp.sv
// ---------------------------------------------------------------------------
// issue_queue_mp
// Parametrised multi-port in-order issue queue between rename/dispatch and
// issue select. Up to IN_LANES elements enter per cycle (all-or-nothing),
// up to OUT_LANES leave per cycle (request clamped to what is present).
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset (priority over flush)
//   flush       synchronous clear of all entries
//   in_data     enqueue elements, lane 0 oldest in [DATA_W-1:0]
//   in_num      number of valid enqueue lanes, packed from lane 0
//   in_ready    in_num elements fit this cycle (combinational on in_num)
//   out_num     number of elements the consumer takes this cycle
//   out_data    oldest OUT_LANES entries, lane 0 oldest, zero when invalid
//   out_valid   bit i set iff count > i
//   avail       min(count, OUT_LANES)
//   count       current occupancy
//   free_slots  DEPTH - count
// ---------------------------------------------------------------------------
module issue_queue_mp #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned IN_LANES  = 4,
    parameter int unsigned OUT_LANES = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic [IN_LANES*DATA_W-1:0]        in_data,
    input  logic [$clog2(IN_LANES+1)-1:0]     in_num,
    output logic                              in_ready,
    input  logic [$clog2(OUT_LANES+1)-1:0]    out_num,
    output logic [OUT_LANES*DATA_W-1:0]       out_data,
    output logic [OUT_LANES-1:0]              out_valid,
    output logic [$clog2(OUT_LANES+1)-1:0]    avail,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    output logic [$clog2(DEPTH+1)-1:0]        free_slots
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned INN_W  = $clog2(IN_LANES + 1);
    localparam int unsigned OUTN_W = $clog2(OUT_LANES + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic [CNT_W-1:0]  w_free;
    logic [OUTN_W-1:0] w_avail;
    logic [OUTN_W-1:0] w_deq;
    logic              w_in_legal;
    logic              w_enq;

    // Occupancy-derived status, all from registered count
    assign w_free     = CNT_W'(DEPTH) - r_count;
    assign w_avail    = (r_count > CNT_W'(OUT_LANES)) ? OUTN_W'(OUT_LANES)
                                                      : OUTN_W'(r_count);
    assign count      = r_count;
    assign free_slots = w_free;
    assign avail      = w_avail;

    // Oversized in_num is illegal and simply never accepted
    assign w_in_legal = (in_num <= INN_W'(IN_LANES));
    assign in_ready   = w_in_legal && (CNT_W'(in_num) <= w_free);
    assign w_enq      = in_ready && (in_num != '0);

    // Consumer request clamped to what is actually present
    assign w_deq = (out_num > w_avail) ? w_avail : out_num;

    // Pointer and occupancy update; rst over flush over normal traffic
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_head <= r_head + PTR_W'(in_num);
            end
            r_tail  <= r_tail + PTR_W'(w_deq);
            r_count <= r_count + (w_enq ? CNT_W'(in_num) : CNT_W'(0))
                               - CNT_W'(w_deq);
        end
    end

    // Storage write; contents are intentionally left unreset
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_enq) begin
            for (int i = 0; i < int'(IN_LANES); i++) begin
                if (INN_W'(i) < in_num) begin
                    r_mem[r_head + PTR_W'(i)] <= in_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Read side: oldest entries from tail, invalid lanes forced to zero
    always_comb begin
        out_data  = '0;
        out_valid = '0;
        for (int i = 0; i < int'(OUT_LANES); i++) begin
            out_valid[i] = (r_count > CNT_W'(i));
            if (out_valid[i]) begin
                out_data[i*DATA_W +: DATA_W] = r_mem[r_tail + PTR_W'(i)];
            end
        end
    end

endmodule

// File: tb/tb_issue_queue_mp.sv
// ---------------------------------------------------------------------------
// tb_issue_queue_mp
// Directed bench for issue_queue_mp (DEPTH=16, IN_LANES=4, OUT_LANES=2,
// DATA_W=32). A queue model holds the expected contents in order: entries are
// pushed when an enqueue is accepted and popped on each dequeue, and the
// head of the model is compared against out_data lanes.
// ---------------------------------------------------------------------------
module tb_issue_queue_mp;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned DEPTH     = 16;
    localparam int unsigned IN_LANES  = 4;
    localparam int unsigned OUT_LANES = 2;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          flush;
    logic [IN_LANES*DATA_W-1:0]    in_data;
    logic [2:0]                    in_num;
    logic                          in_ready;
    logic [1:0]                    out_num;
    logic [OUT_LANES*DATA_W-1:0]   out_data;
    logic [OUT_LANES-1:0]          out_valid;
    logic [1:0]                    avail;
    logic [4:0]                    count;
    logic [4:0]                    free_slots;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb[$];
    int          m_count  = 0;
    logic [31:0] seq      = 32'd0;

    always #5 clk = ~clk;

    issue_queue_mp #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .IN_LANES (IN_LANES),
        .OUT_LANES(OUT_LANES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_data   (in_data),
        .in_num    (in_num),
        .in_ready  (in_ready),
        .out_num   (out_num),
        .out_data  (out_data),
        .out_valid (out_valid),
        .avail     (avail),
        .count     (count),
        .free_slots(free_slots)
    );

    // in_num beyond IN_LANES is never legal stimulus
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            assert (in_num <= 3'(IN_LANES)) else begin
                failures++;
                $error("FAIL in_num_legal observed=%0d expected<=%0d", in_num, IN_LANES);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int          avl;
        logic [31:0] e0;
        logic [31:0] e1;
        avl = (m_count > 2) ? 2 : m_count;
        e0  = (sb.size() > 0) ? sb[0] : 32'd0;
        e1  = (sb.size() > 1) ? sb[1] : 32'd0;
        chk({tag, ":count"},      64'(count),      64'(m_count));
        chk({tag, ":free_slots"}, 64'(free_slots), 64'(DEPTH - m_count));
        chk({tag, ":out_valid"},  64'(out_valid),  64'({m_count > 1, m_count > 0}));
        chk({tag, ":avail"},      64'(avail),      64'(avl));
        chk({tag, ":lane0"},      64'(out_data[31:0]),  64'(e0));
        chk({tag, ":lane1"},      64'(out_data[63:32]), 64'(e1));
    endtask

    // One clock of stimulus; model updated for the same edge, state checked after
    task automatic step(input string tag, input int n_in, input logic [31:0] base,
                        input int n_out, input logic fl, input logic rs);
        int   avl;
        int   deq;
        logic acc;
        in_num = 3'(n_in);
        for (int i = 0; i < int'(IN_LANES); i++) begin
            in_data[i*DATA_W +: DATA_W] = (i < n_in) ? base + 32'(i)
                                                     : 32'hDEAD_0000 + 32'(i);
        end
        out_num = 2'(n_out);
        flush   = fl;
        rst     = rs;
        #1;
        acc = (n_in <= int'(DEPTH) - m_count);
        chk({tag, ":in_ready"}, 64'(in_ready), 64'(acc));
        if (rs || fl) begin
            sb.delete();
        end else begin
            avl = (m_count > 2) ? 2 : m_count;
            deq = (n_out > avl) ? avl : n_out;
            repeat (deq) void'(sb.pop_front());
            if (acc) begin
                for (int i = 0; i < n_in; i++) sb.push_back(base + 32'(i));
            end
        end
        m_count = sb.size();
        @(posedge clk);
        #1;
        in_num  = 3'd0;
        out_num = 2'd0;
        flush   = 1'b0;
        rst     = 1'b0;
        check_state(tag);
    endtask

    initial begin
        rst     = 1'b1;
        flush   = 1'b0;
        in_num  = 3'd0;
        out_num = 2'd0;
        in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: reset state
        check_state("reset");
        in_num = 3'd4;
        #1;
        chk("reset:in_ready4", 64'(in_ready), 64'(1));
        in_num = 3'd0;

        // 2: basic enqueue then dequeue of two
        step("enq3", 3, 32'hA0, 0, 1'b0, 1'b0);
        step("deq2", 0, 32'h0, 2, 1'b0, 1'b0);

        // 3: fill to 14, refused enqueue, refused enqueue with dequeue, fill to full
        step("fill_a", 4, 32'h100, 0, 1'b0, 1'b0);
        step("fill_b", 4, 32'h110, 0, 1'b0, 1'b0);
        step("fill_c", 4, 32'h120, 0, 1'b0, 1'b0);
        step("fill_d", 1, 32'h130, 0, 1'b0, 1'b0);
        step("refuse", 3, 32'h140, 0, 1'b0, 1'b0);
        step("refuse_deq", 3, 32'h150, 2, 1'b0, 1'b0);
        step("accept2", 2, 32'h160, 0, 1'b0, 1'b0);
        step("to_full", 2, 32'h170, 0, 1'b0, 1'b0);
        step("full_refuse", 1, 32'h180, 0, 1'b0, 1'b0);
        step("full_deq", 0, 32'h0, 2, 1'b0, 1'b0);
        step("enq_deq", 2, 32'h190, 2, 1'b0, 1'b0);

        // 4: sequential data across the pointer wrap
        step("wrap_flush", 0, 32'h0, 0, 1'b1, 1'b0);
        step("prime", 2, seq, 0, 1'b0, 1'b0);
        seq += 32'd2;
        for (int r = 0; r < 5; r++) begin
            step("round", 4, seq, 2, 1'b0, 1'b0);
            seq += 32'd4;
        end
        while (m_count > 0) step("drain", 0, 32'h0, 2, 1'b0, 1'b0);

        // 5: dequeue request larger than occupancy
        step("one", 1, 32'h55, 0, 1'b0, 1'b0);
        step("clamp", 0, 32'h0, 2, 1'b0, 1'b0);
        step("empty_clamp", 0, 32'h0, 2, 1'b0, 1'b0);

        // 6: flush and reset against a same-cycle enqueue
        step("f9a", 4, 32'h200, 0, 1'b0, 1'b0);
        step("f9b", 4, 32'h204, 0, 1'b0, 1'b0);
        step("f9c", 1, 32'h208, 0, 1'b0, 1'b0);
        step("flush_enq", 4, 32'h300, 2, 1'b1, 1'b0);
        in_num = 3'd4;
        #1;
        chk("flush:in_ready4", 64'(in_ready), 64'(1));
        step("r9a", 4, 32'h400, 0, 1'b0, 1'b0);
        step("r9b", 4, 32'h404, 0, 1'b0, 1'b0);
        step("r9c", 1, 32'h408, 0, 1'b0, 1'b0);
        step("rst_enq", 4, 32'h500, 2, 1'b0, 1'b1);
        step("post_rst", 2, 32'h600, 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
